// File: rtl/spmm_out_drain.sv
// Purpose : fetch an N x N SpMM result in 4-row beats, buffer it, then stream it out one row at a time.
// Latency : out_start one cycle after out_ready is sampled; first row valid N/4 edges after that sample.
// Backpressure: row_valid/row_ready handshake; a stalled row holds data, index and last flag stable.
//
// Ports:
//   clock      - single clock, all state updates on its rising edge
//   reset      - asynchronous active-low reset
//   out_ready  - SpMM result is available (sampled only in IDLE)
//   out_start  - one-cycle pulse requesting the result (FETCH, beat 0)
//   out_data   - result beat, 4 rows of N elements of W bits
//   row_valid  - row_data holds a valid row (high throughout DRAIN)
//   row_ready  - downstream accepts the presented row
//   row_data   - presented row, zero when row_valid is low
//   row_idx    - index of the presented row, zero when row_valid is low
//   row_last   - presented row is row N-1
//   busy       - block is not IDLE
//   row_sum    - unsigned sum of the presented row (only with SPMM_OUT_DRAIN_ROW_SUM_EN)
//
// Optional feature macro: SPMM_OUT_DRAIN_ROW_SUM_EN adds the row_sum output and its per-row store.

module spmm_out_drain #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       out_ready,
  output logic                       out_start,
  input  logic [3:0][N-1:0][W-1:0]   out_data,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [N-1:0][W-1:0]        row_data,
  output logic [$clog2(N)-1:0]       row_idx,
  output logic                       row_last,
  output logic                       busy
`ifdef SPMM_OUT_DRAIN_ROW_SUM_EN
  ,
  output logic [W+$clog2(N)-1:0]     row_sum
`endif
);

  localparam int RW = $clog2(N);
  // N/4 beats per fetch; keep at least one bit so N=4 still has a counter.
  localparam int BW = (N > 4) ? $clog2(N / 4) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N / 4 - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   beat_q;
  logic [RW-1:0]   row_q;
  logic [N-1:0][W-1:0] buf_q [N];
  logic [RW-1:0]   wr_base;

  // Control FSM: out_ready only matters in IDLE, so a transaction finishing
  // on this edge cannot be re-armed until the next edge sees IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      row_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (out_ready) begin
            state_q <= FETCH;
            beat_q  <= '0;
          end
        end
        FETCH: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= DRAIN;
            beat_q  <= '0;
            row_q   <= '0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        DRAIN: begin
          if (row_ready) begin
            if (row_q == LAST_ROW) begin
              state_q <= IDLE;
              row_q   <= '0;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat b lands in rows 4b..4b+3; the cast drops the spare bit for N=4.
  assign wr_base = RW'({beat_q, 2'b00});

  // Row buffer is data-only: contents after reset are don't-care.
  always_ff @(posedge clock) begin
    if (state_q == FETCH) begin
      for (int i = 0; i < 4; i++) begin
        buf_q[wr_base + RW'(i)] <= out_data[i];
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_start = (state_q == FETCH) && (beat_q == '0);
  assign row_valid = (state_q == DRAIN);
  assign row_data  = row_valid ? buf_q[row_q] : '0;
  assign row_idx   = row_valid ? row_q : '0;
  assign row_last  = row_valid && (row_q == LAST_ROW);

`ifdef SPMM_OUT_DRAIN_ROW_SUM_EN
  localparam int SW = W + RW;

  logic [SW-1:0] sum_q [N];

  function automatic logic [SW-1:0] row_total(input logic [N-1:0][W-1:0] r);
    logic [SW-1:0] s;
    s = '0;
    for (int c = 0; c < N; c++) begin
      s = s + SW'(r[c]);
    end
    return s;
  endfunction

  // Sums are formed while the beat is captured so row_sum tracks row_data.
  always_ff @(posedge clock) begin
    if (state_q == FETCH) begin
      for (int i = 0; i < 4; i++) begin
        sum_q[wr_base + RW'(i)] <= row_total(out_data[i]);
      end
    end
  end

  assign row_sum = row_valid ? sum_q[row_q] : '0;
`endif

endmodule

// File: tb/tb_spmm_out_drain.sv
module tb_spmm_out_drain;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int RW = 4;
  localparam int SW = W + RW;

  typedef logic [N-1:0][W-1:0] row_t;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     out_ready;
  logic                     out_start;
  logic [3:0][N-1:0][W-1:0] out_data;
  logic                     row_valid;
  logic                     row_ready;
  row_t                     row_data;
  logic [RW-1:0]            row_idx;
  logic                     row_last;
  logic                     busy;
`ifdef SPMM_OUT_DRAIN_ROW_SUM_EN
  logic [SW-1:0]            row_sum;
`endif

  spmm_out_drain #(.N(N), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .out_ready (out_ready),
    .out_start (out_start),
    .out_data  (out_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .busy      (busy)
`ifdef SPMM_OUT_DRAIN_ROW_SUM_EN
    ,
    .row_sum   (row_sum)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: the full matrix the producer serves, plus what the sink saw.
  row_t          mat [N];
  row_t          got_data [$];
  logic [RW-1:0] got_idx [$];
  logic          got_last [$];
  logic [SW-1:0] got_sum [$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = W'($urandom);
  endfunction

  function automatic int model_sum(input int r);
    int s = 0;
    for (int c = 0; c < N; c++) s += int'(mat[r][c]);
    return s;
  endfunction

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Serve the four beats starting in the out_start cycle; counts stray out_start pulses.
  task automatic feed_beats(output int extra_starts);
    extra_starts = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) out_data[i] = mat[4 * k + i];
      @(negedge clock);
      if (out_start) extra_starts++;
    end
  endtask

  // Sink: records accepted rows, stalls stall_n cycles on stall_row.
  task automatic collect_rows(input int stall_row, input int stall_n,
                              output int held, output bit stable,
                              output int cycles, output int starts);
    row_t first;
    int   stalls = 0;
    held = 0; stable = 1'b1; cycles = 0; starts = 0;
    first = '0;
    got_data.delete(); got_idx.delete(); got_last.delete(); got_sum.delete();
    for (int k = 0; k < 300; k++) begin
      if (!row_valid) break;
      cycles++;
      if (out_start) starts++;
      if (int'(row_idx) == stall_row) begin
        if (held == 0) first = row_data;
        else if (row_data !== first) stable = 1'b0;
        held++;
      end
      if (int'(row_idx) == stall_row && stalls < stall_n) begin
        row_ready = 1'b0;
        stalls++;
      end else begin
        row_ready = 1'b1;
        got_data.push_back(row_data);
        got_idx.push_back(row_idx);
        got_last.push_back(row_last);
`ifdef SPMM_OUT_DRAIN_ROW_SUM_EN
        got_sum.push_back(row_sum);
`else
        got_sum.push_back('0);
`endif
      end
      @(negedge clock);
    end
    row_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (busy !== 1'b0 || row_valid !== 1'b0 || out_start !== 1'b0 || row_data !== '0) begin
      $display("FAIL reset_idle: busy=%b row_valid=%b out_start=%b, required all 0", busy, row_valid, out_start);
    end else n_pass++;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    n_checks++;
    if (out_start !== 1'b1) $display("FAIL reset_pre_start: out_start=%b required 1", out_start);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out_start !== 1'b0 || busy !== 1'b0 || row_valid !== 1'b0 || row_last !== 1'b0) begin
      $display("FAIL reset_async: out_start=%b busy=%b row_valid=%b row_last=%b, required 0", out_start, busy, row_valid, row_last);
    end else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    int held, cycles, starts;
    bit stable;
    row_t e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = W'((r + c) % 256);
    n_checks++;
    if (out_start !== 1'b0) $display("FAIL basic_no_early_start: out_start=%b required 0", out_start);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    n_checks++;
    if (out_start !== 1'b1 || busy !== 1'b1 || row_valid !== 1'b0 || row_data !== '0 || row_idx !== '0) begin
      $display("FAIL basic_start: out_start=%b busy=%b row_valid=%b row_idx=%0d, required 1 1 0 0", out_start, busy, row_valid, row_idx);
    end else n_pass++;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) out_data[i] = mat[4 * k + i];
      @(negedge clock);
      if (k < 3) begin
        n_checks++;
        if (out_start !== 1'b0 || row_valid !== 1'b0) begin
          $display("FAIL basic_fetch_beat%0d: out_start=%b row_valid=%b required 0 0", k + 1, out_start, row_valid);
        end else n_pass++;
      end
    end
    n_checks++;
    if (row_valid !== 1'b1) $display("FAIL basic_first_row_latency: row_valid=%b required 1", row_valid);
    else n_pass++;
    collect_rows(-1, 0, held, stable, cycles, starts);
    n_checks++;
    if (got_data.size() != N || cycles != N) begin
      $display("FAIL basic_row_count: rows=%0d cycles=%0d required %0d %0d", got_data.size(), cycles, N, N);
    end else n_pass++;
    for (int r = 0; r < N && r < got_data.size(); r++) begin
      for (int c = 0; c < N; c++) e[c] = W'((r + c) % 256);
      n_checks++;
      if (got_data[r] !== e || got_idx[r] !== RW'(r) || got_last[r] !== (r == N - 1)) begin
        $display("FAIL basic_row%0d: data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                 r, got_data[r], got_idx[r], got_last[r], e, r, (r == N - 1));
      end else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0 || row_valid !== 1'b0 || row_last !== 1'b0) begin
      $display("FAIL basic_done: busy=%b row_valid=%b row_last=%b required 0", busy, row_valid, row_last);
    end else n_pass++;
  endtask

  task automatic test_stall();
    int held, cycles, starts, extra;
    bit stable, ok;
    fill_random();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    wait_start(ok);
    n_checks++;
    if (!ok) $display("FAIL stall_start_timeout: out_start=%b required 1", out_start);
    else n_pass++;
    feed_beats(extra);
    collect_rows(5, 3, held, stable, cycles, starts);
    n_checks++;
    if (held != 4 || !stable) $display("FAIL stall_hold: held=%0d stable=%b required 4 1", held, stable);
    else n_pass++;
    n_checks++;
    if (got_data.size() != N || cycles != N + 3) begin
      $display("FAIL stall_count: rows=%0d cycles=%0d required %0d %0d", got_data.size(), cycles, N, N + 3);
    end else n_pass++;
    for (int r = 0; r < N && r < got_data.size(); r++) begin
      n_checks++;
      if (got_data[r] !== mat[r] || got_idx[r] !== RW'(r)) begin
        $display("FAIL stall_row%0d: data=%h idx=%0d required data=%h idx=%0d", r, got_data[r], got_idx[r], mat[r], r);
      end else n_pass++;
    end
  endtask

  task automatic test_hold_ready();
    int held, cycles, starts, extra;
    bit stable, ok;
    fill_random();
    out_ready = 1'b1;
    @(negedge clock);
    wait_start(ok);
    n_checks++;
    if (!ok) $display("FAIL hold_start_timeout: out_start=%b required 1", out_start);
    else n_pass++;
    feed_beats(extra);
    collect_rows(-1, 0, held, stable, cycles, starts);
    n_checks++;
    if (extra + starts != 0) $display("FAIL hold_stray_start: pulses=%0d required 0", extra + starts);
    else n_pass++;
    n_checks++;
    if (got_data.size() != N || got_data[0] !== mat[0] || got_data[N-1] !== mat[N-1]) begin
      $display("FAIL hold_rows: rows=%0d required %0d with matching data", got_data.size(), N);
    end else n_pass++;
    n_checks++;
    if (out_start !== 1'b0) $display("FAIL hold_rearm_early: out_start=%b required 0", out_start);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (out_start !== 1'b1) $display("FAIL hold_rearm: out_start=%b required 1", out_start);
    else n_pass++;
    out_ready = 1'b0;
    #2 reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset_fetch();
    int held, cycles, starts, fetch_cnt;
    bit stable, ok;
    fill_random();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    wait_start(ok);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) out_data[i] = mat[4 * k + i];
      @(negedge clock);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_start !== 1'b0) $display("FAIL rf_abort: busy=%b out_start=%b required 0 0", busy, out_start);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    fill_random();
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    wait_start(ok);
    n_checks++;
    if (!ok) $display("FAIL rf_start_timeout: out_start=%b required 1", out_start);
    else n_pass++;
    fetch_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (!(busy && !row_valid)) break;
      fetch_cnt++;
      if (fetch_cnt <= 4)
        for (int i = 0; i < 4; i++) out_data[i] = mat[4 * (fetch_cnt - 1) + i];
      @(negedge clock);
    end
    n_checks++;
    if (fetch_cnt != 4) $display("FAIL rf_beats: capture beats=%0d required 4", fetch_cnt);
    else n_pass++;
    collect_rows(-1, 0, held, stable, cycles, starts);
    n_checks++;
    if (got_data.size() != N) $display("FAIL rf_row_count: rows=%0d required %0d", got_data.size(), N);
    else n_pass++;
    for (int r = 0; r < N && r < got_data.size(); r++) begin
      n_checks++;
      if (got_data[r] !== mat[r]) $display("FAIL rf_row%0d: data=%h required %h", r, got_data[r], mat[r]);
      else n_pass++;
    end
  endtask

`ifdef SPMM_OUT_DRAIN_ROW_SUM_EN
  task automatic test_row_sum();
    int held, cycles, starts, extra;
    bit stable, ok;
    fill_random();
    for (int c = 0; c < N; c++) begin
      mat[0][c] = 8'd255;
      mat[1][c] = 8'd0;
    end
    n_checks++;
    if (row_sum !== '0) $display("FAIL sum_idle: row_sum=%0d required 0", row_sum);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    wait_start(ok);
    feed_beats(extra);
    collect_rows(-1, 0, held, stable, cycles, starts);
    n_checks++;
    if (got_sum.size() != N || got_sum[0] !== SW'(4080) || got_sum[1] !== '0) begin
      $display("FAIL sum_extremes: rows=%0d sum0=%0d sum1=%0d required 4080 0", got_sum.size(), got_sum[0], got_sum[1]);
    end else n_pass++;
    for (int r = 2; r < N && r < got_sum.size(); r++) begin
      n_checks++;
      if (got_sum[r] !== SW'(model_sum(r))) $display("FAIL sum_row%0d: row_sum=%0d required %0d", r, got_sum[r], model_sum(r));
      else n_pass++;
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    out_ready = 1'b0;
    row_ready = 1'b0;
    out_data  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_basic();
    test_stall();
    test_hold_ready();
    test_reset_fetch();
`ifdef SPMM_OUT_DRAIN_ROW_SUM_EN
    test_row_sum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/spmm_out_drain.md
SPMM_OUT_DRAIN -- requirements
Module: spmm_out_drain

Interface
REQ-001 SHALL have parameter N, default 16: matrix dimension; power of two, at least 4.
REQ-002 SHALL have parameter W, default 8: element width in bits.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port out_ready, input, 1: SpMM result available.
REQ-006 SHALL have port out_start, output, 1: one-cycle pulse requesting the SpMM result.
REQ-007 SHALL have port out_data, input, 4 x N x W: SpMM result beat, 4 rows per beat.
REQ-008 SHALL have port row_valid, output, 1: row_data holds a valid row.
REQ-009 SHALL have port row_ready, input, 1: downstream accepts the row.
REQ-010 SHALL have port row_data, output, N x W: one result row.
REQ-011 SHALL have port row_idx, output, clog2(N): index of the presented row.
REQ-012 SHALL have port row_last, output, 1: the presented row is row N-1.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, FETCH and DRAIN, plus an N x N x W row buffer, a beat counter of clog2(N/4) bits (1 bit minimum) and a row counter of clog2(N) bits.
REQ-015 SHALL, in IDLE, move to FETCH with beat=0 on a rising edge where out_ready=1; out_ready SHALL be ignored in every other state.
REQ-016 SHALL drive out_start=1 only while state=FETCH and beat=0, giving exactly one pulse per transaction.
REQ-017 SHALL, on each FETCH cycle, write out_data[i] into buffer row 4*beat+i for i=0..3, starting with the out_start cycle itself.
REQ-018 SHALL increment beat each FETCH cycle, and after the capture at beat=N/4-1 go to DRAIN with row=0; for N=4, FETCH SHALL last exactly one cycle.
REQ-019 SHALL drive row_valid=1 throughout DRAIN and present row_data=buffer[row], row_idx=row and row_last=(row==N-1).
REQ-020 SHALL advance row on an edge with row_valid&&row_ready; accepting row N-1 SHALL return the block to IDLE.
REQ-021 SHALL hold row_data, row_idx and row_last stable while row_valid=1 and row_ready=0, with no rows skipped or duplicated.
REQ-022 SHALL drive row_data=0, row_idx=0 and row_last=0 whenever row_valid=0.
REQ-023 SHALL achieve the following latency: out_ready sampled high at edge t gives out_start high in cycle t..t+1, and the first row_valid N/4 edges later; with row_ready held high, one row SHALL be accepted per cycle.
REQ-024 SHALL not capture a new out_ready on the same edge that the last row is accepted; re-arm SHALL occur on the next edge sampled in IDLE.

Reset
REQ-025 SHALL, on reset=0, force IDLE with beat=0 and row=0 immediately, without waiting for a clock edge; out_start, row_valid, row_last and busy SHALL read 0.
REQ-026 SHALL abandon any FETCH or DRAIN in progress when reset is asserted; buffer contents are not cleared and are don't-care.
REQ-027 SHALL, after reset=1, make its first state change no earlier than the next rising clock edge.

Configuration
REQ-028 SHALL, with macro SPMM_OUT_DRAIN_ROW_SUM_EN defined, add output row_sum of width W+clog2(N) equal to the unsigned sum of the presented row's N elements.
REQ-029 SHALL compute that row sum per row at capture and store it, so row_sum is valid with row_valid; row_sum SHALL read 0 when row_valid=0 and under reset.
REQ-030 SHALL, without SPMM_OUT_DRAIN_ROW_SUM_EN, omit the row_sum port and its logic; all other behaviour SHALL be identical.

Verification (N=16, W=8)
REQ-031 SHALL pass this scenario: reset=0 mid-cycle -> out_start=0, row_valid=0 and busy=0 immediately, before any clock edge.
REQ-032 SHALL pass this scenario: out_ready pulsed at edge t, element (r,c)=(r+c) mod 256, row_ready held high -> out_start high in t..t+1 only; rows 0..15 on consecutive cycles from edge t+4, row r element c=(r+c), row_last only on row 15, busy drops after row 15.
REQ-033 SHALL pass this scenario: row_ready low 3 cycles while row_idx=5 -> row 5 held stable for 4 cycles, next row is 6.
REQ-034 SHALL pass this scenario: out_ready held high throughout -> no out_start during FETCH/DRAIN; a second out_start occurs 2 cycles after row 15 is accepted.
REQ-035 SHALL pass this scenario: reset asserted during FETCH beat 2, then released and out_ready pulsed -> a clean new transaction with exactly 4 capture beats and 16 rows.
REQ-036 SHALL pass this scenario: with SPMM_OUT_DRAIN_ROW_SUM_EN, a row of all 255 -> row_sum=4080, and an all-zero row -> row_sum=0.
